// File: rtl/reed_solomon_encoder.sv
// ---------------------------------------------------------------------------
// reed_solomon_encoder
// Systematic RS(255,239) encoder over GF(2^8) (poly 0x11D, alpha = 0x02,
// first consecutive root alpha^0). Message bytes pass through unchanged,
// followed by 16 parity bytes taken from a 16-stage LFSR divider.
// K < 239 gives a shortened code; parity count stays 16.
// ---------------------------------------------------------------------------
module reed_solomon_encoder #(
    parameter int K = 239
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       overrun
);

    localparam int NPAR = 16;

    // Generator coefficients g15 (MSB byte) down to g0 (LSB byte) of
    // g(x) = prod_{i=0..15} (x + alpha^i); the leading x^16 term is implicit.
    localparam logic [8*NPAR-1:0] G_COEF = {
        8'd59,  8'd13,  8'd104, 8'd189, 8'd68,  8'd209, 8'd30,  8'd8,
        8'd163, 8'd65,  8'd41,  8'd229, 8'd98,  8'd50,  8'd36,  8'd59
    };

    localparam logic [7:0] K_LAST   = 8'(K - 1);
    localparam logic [7:0] PAR_LAST = 8'(NPAR - 1);

    typedef enum logic {
        ST_DATA,
        ST_PARITY
    } state_t;

    // GF(2^8) multiply; with b tied to a constant this folds to an XOR tree.
    // NOTE: blocking assignments are correct here -- a function models
    // combinational logic evaluated in order, not clocked state.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    state_t     r_state;
    logic [7:0] r_lfsr [NPAR];
    logic [7:0] r_cnt;
    logic [7:0] r_data_out;
    logic       r_valid_out;
    logic       r_overrun;

    logic       w_accept;
    logic [7:0] w_fb;
    logic [7:0] w_prod [NPAR];

    assign ready    = (r_state == ST_DATA);
    assign w_accept = valid_in && ready;
    assign w_fb     = data_in ^ r_lfsr[NPAR-1];

    for (genvar gi = 0; gi < NPAR; gi++) begin : g_mul
        assign w_prod[gi] = gf_mul(w_fb, G_COEF[8*gi +: 8]);
    end

    // Codeword FSM: pass message bytes while dividing, then shift out parity.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_DATA;
            r_cnt       <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_overrun   <= 1'b0;
            // NOTE: the LFSR array is reset on purpose -- an aborted codeword
            // must not leak its remainder into the next one.
            for (int i = 0; i < NPAR; i++) r_lfsr[i] <= '0;
        end else begin
            r_valid_out <= 1'b0;
            if (valid_in && !ready) r_overrun <= 1'b1;

            if (r_state == ST_DATA) begin
                if (w_accept) begin
                    r_data_out  <= data_in;
                    r_valid_out <= 1'b1;
                    r_lfsr[0]   <= w_prod[0];
                    for (int i = 1; i < NPAR; i++) r_lfsr[i] <= r_lfsr[i-1] ^ w_prod[i];
                    if (r_cnt == K_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_PARITY;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end else begin
                r_data_out  <= r_lfsr[NPAR-1];
                r_valid_out <= 1'b1;
                r_lfsr[0]   <= '0;
                for (int i = 1; i < NPAR; i++) r_lfsr[i] <= r_lfsr[i-1];
                if (r_cnt == PAR_LAST) begin
                    r_cnt   <= '0;
                    r_state <= ST_DATA;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign overrun   = r_overrun;

endmodule

// File: doc/reed_solomon_encoder.md
# reed_solomon_encoder

Systematic RS(255,239) encoder over GF(2^8): the transmit-side counterpart of `reed_solomon_decoder`. It takes a byte stream of K message symbols and emits the K symbols unchanged, followed by 16 parity symbols, forming one codeword. It sits in the AFU `clk` domain between the requestor and the decoder. Its output byte port matches the decoder's input, so host data can be encoded, corrupted and looped through the decoder for end-to-end tests.

## Interface
Parameters:
- `K`, 239: message symbols per codeword. Legal range 1..239; values below 239 give a shortened code. Parity count is fixed at 16 (t = 8).

Ports:
- `clk`  in  1: AFU clock (pClkDiv2 domain).
- `reset`  in  1: one clock; reset is synchronous and active-high.
- `data_in`  in  8: message symbol.
- `valid_in`  in  1: `data_in` valid this cycle.
- `ready`  out  1: encoder accepts a symbol this cycle; a byte is accepted when `valid_in && ready`.
- `data_out`  out  8: codeword symbol, registered.
- `valid_out`  out  1: `data_out` valid, registered.
- `overrun`  out  1: sticky. Set when `valid_in` is high while `ready` is low. Cleared only by reset.

## Operation
- Field: GF(2^8), primitive polynomial 0x11D, α = 0x02.
- Generator: g(x) = Π_{i=0..15}(x − α^i), monic, with coefficients g15..g0 held as constants.
- State: 16×8-bit LFSR `r[15:0]`, symbol counter `cnt` (8 bits), FSM {DATA, PARITY}.
- DATA state (`ready` = 1), on each accepted byte:
  - fb = `data_in` ^ r[15].
  - r[i] ← r[i−1] ^ gmul(fb, g_i) for i = 15..1; r[0] ← gmul(fb, g0).
  - `data_out` ← `data_in`, `valid_out` ← 1.
  - `cnt` ← `cnt` + 1.
- On the K-th accepted byte: `cnt` ← 0 and the FSM moves to PARITY.
- PARITY state (`ready` = 0), each cycle:
  - `data_out` ← r[15], `valid_out` ← 1.
  - r shifts up (r[i] ← r[i−1], r[0] ← 0).
  - `cnt` increments.
  - After the 16th parity symbol: `cnt` ← 0, r is all zero, FSM → DATA.
- Symbol order: the first message byte is the highest-degree coefficient; parity is emitted r[15] first, r[0] last.
- No cycle with `valid_in` low in DATA emits output (`valid_out` = 0). The LFSR and `cnt` hold.
- Overrun: a byte presented while `ready` = 0 is dropped, does not affect the LFSR, and sets `overrun`.
- gmul is purely combinational: constant-coefficient GF multipliers, XOR trees only, no tables in RAM.

## Timing
- Reset values: `ready` = 1, `data_out` = 0, `valid_out` = 0, `overrun` = 0; r = 0, `cnt` = 0, FSM = DATA.
- Latency: accepted byte at edge n → appears on `data_out` with `valid_out` after edge n (1 cycle).
- `ready` is a combinational decode of FSM state. It drops the cycle after the K-th byte is accepted and stays low exactly 16 cycles.
- First parity symbol is output the cycle after the K-th message symbol is output: contiguous with gapless input.
- Throughput: max K symbols per K+16 cycles; back-to-back codewords have no extra bubble beyond the 16 parity cycles.
- Reset mid-codeword, in either state: abort immediately. The next cycle is in DATA with cleared LFSR. No partial parity is emitted.
- `reset` and `valid_in` asserted together: reset wins and the byte is dropped.

## Test plan
- All-zero message, K = 239, gapless → 255 outputs on consecutive cycles, all 0x00; `ready` low for exactly 16 cycles after byte 239.
- Message of 238 × 0x00 then 0x01 → parity bytes equal g15..g0. First parity = α^120 = g15, last parity = α^120 = g0; all bytes must match the software RS model.
- Random messages; 1000 codewords, back-to-back with random `valid_in` gaps → outputs match the golden model. Feeding the codewords through `reed_solomon_decoder` with ≤ 8 random symbol errors injected returns the original message.
- `valid_in` held high through the PARITY phase → 16 bytes dropped, `overrun` = 1 and stays 1; the next codeword is still correct.
- `reset` pulsed at message byte 100, then at parity byte 5 → no further output from the aborted codeword; the following codeword is bit-exact against the model.
- K = 1 shortened code, message 0x01 → output 0x01 then g15..g0; `ready` pattern 1, 0×16, 1.
